// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage LC-3b pipeline: fixed-priority hazard resolution,
// per-latch bubble flags that drive NOP injection, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 imem_stall_i,
    input  logic                 dmem_stall_i,
    input  logic                 br_taken_mem_i,
    input  logic                 ex_is_load_i,
    input  logic [2:0]           ex_dest_i,
    input  logic [2:0]           id_sr1_i,
    input  logic                 id_sr1_valid_i,
    input  logic [2:0]           id_sr2_i,
    input  logic                 id_sr2_valid_i,
    output logic                 load_pc_o,
    output logic                 pc_sel_branch_o,
    output logic                 load_if_id_o,
    output logic                 load_id_ex_o,
    output logic                 load_ex_mem_o,
    output logic                 load_mem_wb_o,
    output logic                 nop_if_id_o,
    output logic                 nop_id_ex_o,
    output logic                 nop_ex_mem_o,
    output logic [2:0]           state_o,
    output logic [CNT_WIDTH-1:0] stall_count_o,
    output logic [CNT_WIDTH-1:0] flush_count_o
);

    typedef enum logic [2:0] {
        StRun    = 3'd0,
        StDstall = 3'd1,
        StFlush  = 3'd2,
        StHazard = 3'd3,
        StIstall = 3'd4
    } decision_e;

    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    decision_e            decision;
    decision_e            state_q;
    logic                 load_use;
    logic                 b_if_id_q,  b_if_id_d;
    logic                 b_id_ex_q,  b_id_ex_d;
    logic                 b_ex_mem_q, b_ex_mem_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

    assign load_use = ex_is_load_i &
                      ((id_sr1_valid_i & (id_sr1_i == ex_dest_i)) |
                       (id_sr2_valid_i & (id_sr2_i == ex_dest_i)));

    always_comb begin
        decision        = StRun;
        load_pc_o       = 1'b1;
        pc_sel_branch_o = 1'b0;
        load_if_id_o    = 1'b1;
        load_id_ex_o    = 1'b1;
        load_ex_mem_o   = 1'b1;
        load_mem_wb_o   = 1'b1;
        b_if_id_d       = 1'b0;
        b_id_ex_d       = 1'b0;
        b_ex_mem_d      = 1'b0;

        if (dmem_stall_i) begin
            // Whole pipe frozen; branch/load-use are re-evaluated once it moves again.
            decision      = StDstall;
            load_pc_o     = 1'b0;
            load_if_id_o  = 1'b0;
            load_id_ex_o  = 1'b0;
            load_ex_mem_o = 1'b0;
            load_mem_wb_o = 1'b0;
            b_if_id_d     = b_if_id_q;
            b_id_ex_d     = b_id_ex_q;
            b_ex_mem_d    = b_ex_mem_q;
        end else if (br_taken_mem_i) begin
            decision        = StFlush;
            pc_sel_branch_o = 1'b1;
            b_if_id_d       = 1'b1;
            b_id_ex_d       = 1'b1;
            b_ex_mem_d      = 1'b1;
        end else if (load_use) begin
            decision     = StHazard;
            load_pc_o    = 1'b0;
            load_if_id_o = 1'b0;
            b_if_id_d    = b_if_id_q;
            b_id_ex_d    = 1'b1;
        end else if (imem_stall_i) begin
            decision  = StIstall;
            load_pc_o = 1'b0;
            b_if_id_d = 1'b1;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!load_pc_o && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
            stall_count_d = stall_count_q + CntOne;
        end
        if ((decision == StFlush) && (flush_count_q != {CNT_WIDTH{1'b1}})) begin
            flush_count_d = flush_count_q + CntOne;
        end
    end

    // Flags reset to 1 so the pipeline reads as empty until the first RUN edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            b_if_id_q     <= 1'b1;
            b_id_ex_q     <= 1'b1;
            b_ex_mem_q    <= 1'b1;
            state_q       <= StRun;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            b_if_id_q     <= b_if_id_d;
            b_id_ex_q     <= b_id_ex_d;
            b_ex_mem_q    <= b_ex_mem_d;
            state_q       <= decision;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign nop_if_id_o   = b_if_id_q;
    assign nop_id_ex_o   = b_id_ex_q;
    assign nop_ex_mem_o  = b_ex_mem_q;
    assign state_o       = state_q;
    assign stall_count_o = stall_count_q;
    assign flush_count_o = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-step expectations are queued when stimulus is
// driven and compared once the clock edge has produced the registered outputs.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       imem;
        logic       dmem;
        logic       br;
        logic       ld;
        logic [2:0] dest;
        logic [2:0] sr1;
        logic       v1;
        logic [2:0] sr2;
        logic       v2;
    } stim_t;

    typedef struct packed {
        logic [2:0]  nop;
        logic [2:0]  st;
        logic [15:0] stall;
        logic [15:0] flush;
    } exp_t;

    logic        clk, reset;
    logic        imem, dmem, br, ld, v1, v2;
    logic [2:0]  dest, sr1, sr2;

    logic        load_pc, pc_sel, l_if, l_ie, l_em, l_mw, n_if, n_ie, n_em;
    logic [2:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_load_pc, s_pc_sel, s_l_if, s_l_ie, s_l_em, s_l_mw, s_n_if, s_n_ie, s_n_em;
    logic [2:0]  s_state;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    pipeline_hazard_ctrl #(.CNT_WIDTH(16)) dut (
        .clk_i(clk), .reset_i(reset), .imem_stall_i(imem), .dmem_stall_i(dmem),
        .br_taken_mem_i(br), .ex_is_load_i(ld), .ex_dest_i(dest), .id_sr1_i(sr1),
        .id_sr1_valid_i(v1), .id_sr2_i(sr2), .id_sr2_valid_i(v2),
        .load_pc_o(load_pc), .pc_sel_branch_o(pc_sel), .load_if_id_o(l_if),
        .load_id_ex_o(l_ie), .load_ex_mem_o(l_em), .load_mem_wb_o(l_mw),
        .nop_if_id_o(n_if), .nop_id_ex_o(n_ie), .nop_ex_mem_o(n_em), .state_o(state),
        .stall_count_o(stall_cnt), .flush_count_o(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_WIDTH(4)) dut_small (
        .clk_i(clk), .reset_i(reset), .imem_stall_i(imem), .dmem_stall_i(dmem),
        .br_taken_mem_i(br), .ex_is_load_i(ld), .ex_dest_i(dest), .id_sr1_i(sr1),
        .id_sr1_valid_i(v1), .id_sr2_i(sr2), .id_sr2_valid_i(v2),
        .load_pc_o(s_load_pc), .pc_sel_branch_o(s_pc_sel), .load_if_id_o(s_l_if),
        .load_id_ex_o(s_l_ie), .load_ex_mem_o(s_l_em), .load_mem_wb_o(s_l_mw),
        .nop_if_id_o(s_n_if), .nop_id_ex_o(s_n_ie), .nop_ex_mem_o(s_n_em), .state_o(s_state),
        .stall_count_o(s_stall_cnt), .flush_count_o(s_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t mk(input logic i_imem, input logic i_dmem, input logic i_br,
                                 input logic i_ld, input logic [2:0] i_dest,
                                 input logic [2:0] i_sr1, input logic i_v1,
                                 input logic [2:0] i_sr2, input logic i_v2);
        stim_t s;
        s.imem = i_imem; s.dmem = i_dmem; s.br = i_br; s.ld = i_ld; s.dest = i_dest;
        s.sr1 = i_sr1; s.v1 = i_v1; s.sr2 = i_sr2; s.v2 = i_v2;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        imem = s.imem; dmem = s.dmem; br = s.br; ld = s.ld; dest = s.dest;
        sr1 = s.sr1; v1 = s.v1; sr2 = s.sr2; v2 = s.v2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag, input exp_t e);
        check({tag, ".nop"},   32'({n_if, n_ie, n_em}), 32'(e.nop));
        check({tag, ".state"}, 32'(state),              32'(e.st));
        check({tag, ".stall"}, 32'(stall_cnt),          32'(e.stall));
        check({tag, ".flush"}, 32'(flush_cnt),          32'(e.flush));
    endtask

    // Called at a negedge: drive, check decision, queue post-edge expectation, compare after edge.
    task automatic step(input string tag, input stim_t s, input logic [5:0] ec,
                        input logic [2:0] en, input logic [2:0] es,
                        input logic [15:0] est, input logic [15:0] efl);
        exp_t e;
        drive(s);
        #1;
        check({tag, ".loads"}, 32'({load_pc, pc_sel, l_if, l_ie, l_em, l_mw}), 32'(ec));
        e.nop = en; e.st = es; e.stall = est; e.flush = efl;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_regs(tag, exp_q.pop_front());
        @(negedge clk);
    endtask

    localparam logic [5:0] CRun    = 6'b101111;
    localparam logic [5:0] CHaz    = 6'b000111;
    localparam logic [5:0] CFlush  = 6'b111111;
    localparam logic [5:0] CDstall = 6'b000000;
    localparam logic [5:0] CIstall = 6'b001111;

    initial begin
        stim_t idle, haz1;
        exp_t  er;
        idle = mk(0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
        haz1 = mk(0, 0, 0, 1, 3'd3, 3'd3, 1, 3'd0, 0);

        reset = 1'b1;
        drive(idle);
        #2;
        er.nop = 3'b111; er.st = 3'd0; er.stall = 16'd0; er.flush = 16'd0;
        check_regs("reset", er);
        @(negedge clk);
        reset = 1'b0;

        step("run0",   idle, CRun, 3'b000, 3'd0, 16'd0, 16'd0);
        step("haz1",   haz1, CHaz, 3'b010, 3'd3, 16'd1, 16'd0);
        step("run1",   idle, CRun, 3'b000, 3'd0, 16'd1, 16'd0);
        step("novld",  mk(0, 0, 0, 1, 3'd3, 3'd3, 0, 3'd3, 0), CRun, 3'b000, 3'd0, 16'd1, 16'd0);
        step("haz2",   mk(0, 0, 0, 1, 3'd5, 3'd5, 0, 3'd5, 1), CHaz, 3'b010, 3'd3, 16'd2, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step("dstall", mk(0, 1, 1, 1, 3'd3, 3'd3, 1, 3'd0, 0), CDstall, 3'b010, 3'd1,
                 16'(3 + i), 16'd0);
        end
        step("dflush", mk(0, 0, 1, 1, 3'd3, 3'd3, 1, 3'd0, 0), CFlush, 3'b111, 3'd2,
             16'd5, 16'd1);
        step("iflush", mk(1, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0), CFlush, 3'b111, 3'd2,
             16'd5, 16'd2);
        step("run2",   idle, CRun, 3'b000, 3'd0, 16'd5, 16'd2);

        // Asynchronous reset in the middle of a D-cache stall.
        drive(mk(0, 1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0));
        #1;
        check("pre_rst.loads", 32'({load_pc, pc_sel, l_if, l_ie, l_em, l_mw}), 32'(CDstall));
        check("pre_rst.stall", 32'(stall_cnt), 32'd5);
        #1;
        reset = 1'b1;
        #1;
        er.nop = 3'b111; er.st = 3'd0; er.stall = 16'd0; er.flush = 16'd0;
        check_regs("rst_mid", er);
        @(negedge clk);
        reset = 1'b0;
        step("post_rst", idle, CRun, 3'b000, 3'd0, 16'd0, 16'd0);
        step("istall",   mk(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0), CIstall, 3'b100, 3'd4,
             16'd1, 16'd0);

        // Saturation on the narrow-counter instance.
        reset = 1'b1;
        #1;
        check("sat_rst", 32'(s_stall_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(mk(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0));
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check("sat.stall4",  32'(s_stall_cnt), (k > 15) ? 32'd15 : 32'(k));
            check("sat.nop_if",  32'(s_n_if), 32'd1);
            check("sat.stall16", 32'(stall_cnt), 32'(k));
            check("sat.load_pc", 32'(s_load_pc), 32'd0);
        end
        @(negedge clk);
        drive(idle);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
